// File: rtl/gp_reg_pkg.sv
// Shared types and default sizes for the general-purpose register file.
// The control unit uses the same defaults.
package gp_reg_pkg;

  typedef enum logic {
    REG_OP_INC = 1'b0,
    REG_OP_DEC = 1'b1
  } reg_op_e;

  localparam int GP_DATA_W   = 8;
  localparam int GP_NUM_REGS = 8;

endpackage

// File: rtl/gp_reg_cell.sv
// One register of the file: load, increment, decrement or hold.
// A load takes priority over inc/dec. Wrap is flagged only when an inc/dec is actually applied.
module gp_reg_cell
  import gp_reg_pkg::*;
#(
  parameter int          DATA_W  = GP_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              op,
  input  logic              op_sel,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] nxt,
  output logic              wrap
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nxt  = q;
    wrap = 1'b0;
    if (ld) begin
      nxt = ld_data;
    end else if (op) begin
      if (reg_op_e'(op_sel) == REG_OP_DEC) begin
        nxt  = q - 1'b1;
        wrap = (q == '0);
      end else begin
        nxt  = q + 1'b1;
        wrap = &q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= nxt;
  end

endmodule

// File: rtl/gp_reg_file.sv
// Register file with one write port, one inc/dec port and two registered read ports.
// Define GP_REG_FILE_BYPASS_EN for write-first reads; the default build is read-first.
module gp_reg_file
  import gp_reg_pkg::*;
#(
  parameter int          DATA_W   = GP_DATA_W,
  parameter int          NUM_REGS = GP_NUM_REGS,
  parameter logic [DATA_W-1:0] RST_VAL  = '0,
  localparam int         ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              op_en,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic              op_sel,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              op_wrap,
  output logic              collide
);

  logic [NUM_REGS-1:0] ld_vec;
  logic [NUM_REGS-1:0] op_vec;
  logic [NUM_REGS-1:0] wrap_vec;
  logic [DATA_W-1:0]   q_arr   [NUM_REGS];
  logic [DATA_W-1:0]   nxt_arr [NUM_REGS];
  logic [DATA_W-1:0]   rd_a_c;
  logic [DATA_W-1:0]   rd_b_c;

  // Address decode; addresses at or beyond NUM_REGS match no cell, so they are ignored.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    assign ld_vec[i] = wr_en && (wr_addr == ADDR_W'(i));
    assign op_vec[i] = op_en && (op_addr == ADDR_W'(i));

    gp_reg_cell #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (ld_vec[i]),
      .ld_data (wr_data),
      .op      (op_vec[i]),
      .op_sel  (op_sel),
      .q       (q_arr[i]),
      .nxt     (nxt_arr[i]),
      .wrap    (wrap_vec[i])
    );
  end

  // Forwarding reads the cell's next value, which equals its current value when untouched.
  always_comb begin
    rd_a_c = '0;
    rd_b_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef GP_REG_FILE_BYPASS_EN
      if (rd_addr_a == ADDR_W'(i)) rd_a_c = nxt_arr[i];
      if (rd_addr_b == ADDR_W'(i)) rd_b_c = nxt_arr[i];
`else
      if (rd_addr_a == ADDR_W'(i)) rd_a_c = q_arr[i];
      if (rd_addr_b == ADDR_W'(i)) rd_b_c = q_arr[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      op_wrap   <= 1'b0;
      collide   <= 1'b0;
    end else begin
      rd_data_a <= rd_a_c;
      rd_data_b <= rd_b_c;
      op_wrap   <= |wrap_vec;
      collide   <= |(ld_vec & op_vec);
    end
  end

endmodule
